// File: rtl/cacheline_arbiter_pkg.sv
// rtl/cacheline_arbiter_pkg.sv - shared types and widths for the cache-line DFP arbiter
package arb_pkg;
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_LINE_W = 256;

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} arb_owner_t;
endpackage

// File: rtl/cacheline_arbiter_if.sv
// rtl/cacheline_arbiter_if.sv - I-cache, D-cache and line-level DFP signals of the arbiter
interface cacheline_arbiter_if #(
    parameter int ADDR_W = arb_pkg::ARB_ADDR_W,
    parameter int LINE_W = arb_pkg::ARB_LINE_W
);
    logic [ADDR_W-1:0] i_dfp_addr;
    logic              i_dfp_read;
    logic [LINE_W-1:0] i_dfp_rdata;
    logic              i_dfp_resp;

    logic [ADDR_W-1:0] d_dfp_addr;
    logic              d_dfp_read;
    logic              d_dfp_write;
    logic [LINE_W-1:0] d_dfp_wdata;
    logic [LINE_W-1:0] d_dfp_rdata;
    logic              d_dfp_resp;

    logic [ADDR_W-1:0] dfp_addr;
    logic              dfp_read;
    logic              dfp_write;
    logic [LINE_W-1:0] dfp_wdata;
    logic [LINE_W-1:0] dfp_rdata;
    logic              dfp_resp;

    modport slave (
        input  i_dfp_addr, i_dfp_read,
        output i_dfp_rdata, i_dfp_resp,
        input  d_dfp_addr, d_dfp_read, d_dfp_write, d_dfp_wdata,
        output d_dfp_rdata, d_dfp_resp,
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  dfp_rdata, dfp_resp
    );

    modport master (
        output i_dfp_addr, i_dfp_read,
        input  i_dfp_rdata, i_dfp_resp,
        output d_dfp_addr, d_dfp_read, d_dfp_write, d_dfp_wdata,
        input  d_dfp_rdata, d_dfp_resp,
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output dfp_rdata, dfp_resp
    );
endinterface

// File: rtl/cacheline_arbiter.sv
// rtl/cacheline_arbiter.sv - I/D cache-line arbiter onto one DFP port; ARB_ROUND_ROBIN_EN selects round-robin over fixed D priority
module cacheline_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
) (
    input  logic                clk,
    input  logic                rst,
    cacheline_arbiter_if.slave  bus
);
    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              i_req, d_req;
    logic              grant_i, grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    arb_owner_t        ptr_q, ptr_d;
`endif

    assign i_req = bus.i_dfp_read;
    assign d_req = bus.d_dfp_read | bus.d_dfp_write;

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            grant_i = (ptr_q == OWN_I);
            grant_d = (ptr_q == OWN_D);
        end else begin
            grant_i = i_req;
            grant_d = d_req;
        end
`else
        grant_d = d_req;
        grant_i = i_req & ~d_req;
`endif
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        read_d  = read_q;
        write_d = write_q;
        wdata_d = wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                // read+write together from the D-cache degrades to a writeback
                if (grant_d) begin
                    state_d = D_BUSY;
                    addr_d  = bus.d_dfp_addr;
                    wdata_d = bus.d_dfp_wdata;
                    write_d = bus.d_dfp_write;
                    read_d  = bus.d_dfp_read & ~bus.d_dfp_write;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   = OWN_I;
`endif
                end else if (grant_i) begin
                    state_d = I_BUSY;
                    addr_d  = bus.i_dfp_addr;
                    wdata_d = '0;
                    write_d = 1'b0;
                    read_d  = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   = OWN_D;
`endif
                end
            end
            I_BUSY, D_BUSY: begin
                if (bus.dfp_resp) begin
                    state_d = DONE;
                    addr_d  = '0;
                    wdata_d = '0;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q   <= OWN_I;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.dfp_addr  = addr_q;
    assign bus.dfp_read  = read_q;
    assign bus.dfp_write = write_q;
    assign bus.dfp_wdata = wdata_q;

    // responses pass straight through to the owner only; idle/dead-cycle responses vanish
    assign bus.i_dfp_resp  = (state_q == I_BUSY) & bus.dfp_resp;
    assign bus.i_dfp_rdata = (state_q == I_BUSY) ? bus.dfp_rdata : '0;
    assign bus.d_dfp_resp  = (state_q == D_BUSY) & bus.dfp_resp;
    assign bus.d_dfp_rdata = (state_q == D_BUSY) ? bus.dfp_rdata : '0;

`ifndef SYNTHESIS
    illegal_rw_a: assert property (@(posedge clk) disable iff (!rst)
        !(bus.d_dfp_read && bus.d_dfp_write))
        else $warning("d-cache read and write asserted together, treated as write");
    spurious_resp_a: assert property (@(posedge clk) disable iff (!rst)
        !((state_q == IDLE || state_q == DONE) && bus.dfp_resp))
        else $warning("dfp_resp outside a transaction dropped");
`endif
endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb/tb_cacheline_arbiter.sv - randomized scoreboard bench for cacheline_arbiter
module tb_cacheline_arbiter;
    import arb_pkg::*;
    localparam int AW = ARB_ADDR_W;
    localparam int LW = ARB_LINE_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cacheline_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();
    cacheline_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit             own_d;
        logic [AW-1:0]  addr;
        logic           rd;
        logic           wr;
        logic [LW-1:0]  wdata;
    } txn_t;
    typedef struct {
        bit             own_d;
        logic [LW-1:0]  rdata;
    } rsp_t;

    txn_t exp_txn[$];
    rsp_t exp_rsp[$];
    bit   seen_own[$];
    int   n_chk = 0;
    int   n_bad = 0;

    // reference model: a line port is free, busy with one owner, or in its one dead cycle
    typedef enum {M_FREE, M_BUSY, M_DEAD} m_phase_t;
    m_phase_t m_phase = M_FREE;
    bit  m_own_d  = 1'b0;
    bit  m_last_d = 1'b1;
    int  m_lat    = 0;
    bit  got_i, got_d;

    bit  en_i = 0, en_d = 0, a5_mode = 0, no_resp = 0;
    int  keep = 0;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic new_d_req();
        bit w;
        w = $urandom_range(0, 1);
        bus.d_dfp_write = w;
        bus.d_dfp_read  = ~w;
        bus.d_dfp_addr  = $urandom;
        bus.d_dfp_wdata = rand_line();
    endtask

    task automatic model_step();
        bit ir, dr, pick_d;
        txn_t t;
        got_i = 0;
        got_d = 0;
        if (!rst) begin
            m_phase = M_FREE;
            return;
        end
        ir = bus.i_dfp_read;
        dr = bus.d_dfp_read | bus.d_dfp_write;
        case (m_phase)
            M_BUSY: if (bus.dfp_resp) begin
                m_phase = M_DEAD;
                if (m_own_d) got_d = 1; else got_i = 1;
            end
            M_DEAD: m_phase = M_FREE;
            default: if (ir || dr) begin
`ifdef ARB_ROUND_ROBIN_EN
                pick_d = (ir && dr) ? !m_last_d : dr;
`else
                pick_d = dr;
`endif
                m_last_d = pick_d;
                m_own_d  = pick_d;
                m_phase  = M_BUSY;
                m_lat    = no_resp ? 1000 : $urandom_range(0, 3);
                t.own_d  = pick_d;
                t.addr   = pick_d ? bus.d_dfp_addr : bus.i_dfp_addr;
                t.wr     = pick_d & bus.d_dfp_write;
                t.rd     = pick_d ? (bus.d_dfp_read & ~bus.d_dfp_write) : 1'b1;
                t.wdata  = pick_d ? bus.d_dfp_wdata : '0;
                exp_txn.push_back(t);
            end
        endcase
    endtask

    task automatic drive_next();
        rsp_t r;
        // deserializer side
        if (m_phase == M_BUSY && m_lat == 0) begin
            bus.dfp_resp  = 1'b1;
            bus.dfp_rdata = a5_mode ? {(LW/8){8'hA5}} : rand_line();
            r.own_d = m_own_d;
            r.rdata = bus.dfp_rdata;
            exp_rsp.push_back(r);
        end else begin
            bus.dfp_resp  = 1'b0;
            bus.dfp_rdata = rand_line();
            if (m_phase == M_BUSY) m_lat--;
        end
        // owner scribbles on its inputs mid-transaction; the latched copy must not move
        if (m_phase == M_BUSY) begin
            if (m_own_d) begin
                bus.d_dfp_addr  = $urandom;
                bus.d_dfp_wdata = rand_line();
            end else begin
                bus.i_dfp_addr = $urandom;
            end
        end
        if (got_i) begin
            bus.i_dfp_read = (keep == 2) || (keep == 1 && $urandom_range(0, 1) == 1);
            bus.i_dfp_addr = $urandom;
        end else if (!bus.i_dfp_read && en_i && $urandom_range(0, 2) == 0) begin
            bus.i_dfp_read = 1'b1;
            bus.i_dfp_addr = $urandom;
        end
        if (got_d) begin
            if ((keep == 2) || (keep == 1 && $urandom_range(0, 1) == 1)) new_d_req();
            else begin
                bus.d_dfp_read  = 1'b0;
                bus.d_dfp_write = 1'b0;
            end
        end else if (!(bus.d_dfp_read || bus.d_dfp_write) && en_d && $urandom_range(0, 2) == 0) begin
            new_d_req();
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        drive_next();
    endtask

    task automatic run_resps(input int n, input int bound);
        int start, c;
        start = seen_own.size();
        c = 0;
        while (seen_own.size() < start + n && c < bound) begin
            cycle();
            c++;
        end
        chk("resp_timeout", (seen_own.size() >= start + n), 1'b1);
    endtask

    task automatic drain();
        int c;
        en_i = 0;
        en_d = 0;
        keep = 0;
        c = 0;
        while ((bus.i_dfp_read || bus.d_dfp_read || bus.d_dfp_write || m_phase != M_FREE) && c < 200) begin
            cycle();
            c++;
        end
        chk("drain_timeout", (c < 200), 1'b1);
        repeat (2) cycle();
    endtask

    // monitor / scoreboard
    initial begin
        txn_t cur;
        rsp_t r;
        bit   have_cur;
        have_cur = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                have_cur = 0;
                continue;
            end
            if (m_phase == M_BUSY) begin
                if (!have_cur) begin
                    chk("txn_expected", (exp_txn.size() > 0), 1'b1);
                    if (exp_txn.size() > 0) begin
                        cur = exp_txn.pop_front();
                        have_cur = 1;
                    end
                end
                if (have_cur) begin
                    chk("dfp_addr", bus.dfp_addr, cur.addr);
                    chk("dfp_read", bus.dfp_read, cur.rd);
                    chk("dfp_write", bus.dfp_write, cur.wr);
                    chk("dfp_wdata", bus.dfp_wdata, cur.wdata);
                end
            end else begin
                have_cur = 0;
                chk("idle_ctl", {bus.dfp_addr, bus.dfp_read, bus.dfp_write}, '0);
                chk("idle_wdata", bus.dfp_wdata, '0);
            end
            chk("resp_both", (bus.i_dfp_resp && bus.d_dfp_resp), 1'b0);
            if (bus.i_dfp_resp || bus.d_dfp_resp) begin
                chk("resp_expected", (exp_rsp.size() > 0), 1'b1);
                if (exp_rsp.size() > 0) begin
                    r = exp_rsp.pop_front();
                    chk("resp_owner", bus.d_dfp_resp, r.own_d);
                    chk("resp_rdata", bus.d_dfp_resp ? bus.d_dfp_rdata : bus.i_dfp_rdata, r.rdata);
                end
                seen_own.push_back(bus.d_dfp_resp);
            end else if (exp_rsp.size() > 0) begin
                chk("resp_missing", 1'b0, 1'b1);
                void'(exp_rsp.pop_front());
            end
            if (!(m_phase == M_BUSY && !m_own_d)) chk("i_rdata_gated", bus.i_dfp_rdata, '0);
            if (!(m_phase == M_BUSY && m_own_d))  chk("d_rdata_gated", bus.d_dfp_rdata, '0);
        end
    end

    initial begin
        bit pat[4];
        bus.i_dfp_addr  = '0;
        bus.i_dfp_read  = 1'b0;
        bus.d_dfp_addr  = '0;
        bus.d_dfp_read  = 1'b0;
        bus.d_dfp_write = 1'b0;
        bus.d_dfp_wdata = '0;
        bus.dfp_rdata   = '0;
        bus.dfp_resp    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {bus.dfp_addr, bus.dfp_read, bus.dfp_write}, '0);
        chk("rst_wdata", bus.dfp_wdata, '0);
        chk("rst_resp", {bus.i_dfp_resp, bus.d_dfp_resp}, '0);
        chk("rst_i_rdata", bus.i_dfp_rdata, '0);
        chk("rst_d_rdata", bus.d_dfp_rdata, '0);
        rst = 1'b1;
        cycle();

        // lone I read with a recognisable line
        a5_mode = 1;
        bus.i_dfp_read = 1'b1;
        bus.i_dfp_addr = 32'h0000_1000;
        run_resps(1, 20);
        a5_mode = 0;
        drain();

        // lone D writeback
        bus.d_dfp_write = 1'b1;
        bus.d_dfp_addr  = 32'h0000_2000;
        bus.d_dfp_wdata = {8{32'h1234_5678}};
        run_resps(1, 20);
        drain();

        // both held continuously; last grant was D so I goes first under round-robin
        keep = 2;
        bus.i_dfp_read = 1'b1;
        bus.i_dfp_addr = $urandom;
        new_d_req();
        run_resps(4, 80);
`ifdef ARB_ROUND_ROBIN_EN
        pat = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        pat = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int k = 0; k < 4; k++)
            if (seen_own.size() >= 4)
                chk($sformatf("grant_order%0d", k), seen_own[seen_own.size() - 4 + k], pat[k]);
        drain();

        // I keeps requesting through DONE; regrant only after the dead cycle
        keep = 2;
        bus.i_dfp_read = 1'b1;
        bus.i_dfp_addr = $urandom;
        run_resps(3, 60);
        drain();

        // random traffic
        en_i = 1;
        en_d = 1;
        keep = 1;
        repeat (800) cycle();
        drain();

        // reset while D owns the port, with an I request waiting
        no_resp = 1;
        bus.d_dfp_read = 1'b1;
        bus.d_dfp_addr = $urandom;
        for (int c = 0; c < 10 && !(m_phase == M_BUSY && m_own_d); c++) cycle();
        chk("rst_test_busy", (m_phase == M_BUSY && m_own_d), 1'b1);
        cycle();
        #1;
        bus.d_dfp_read = 1'b0;
        bus.i_dfp_read = 1'b1;
        bus.i_dfp_addr = 32'h0000_3000;
        rst = 1'b0;
        #1;
        chk("midrst_ctl", {bus.dfp_addr, bus.dfp_read, bus.dfp_write}, '0);
        chk("midrst_wdata", bus.dfp_wdata, '0);
        chk("midrst_d_rdata", bus.d_dfp_rdata, '0);
        chk("midrst_resp", {bus.i_dfp_resp, bus.d_dfp_resp}, '0);
        m_phase  = M_FREE;
        m_last_d = 1'b1;
        exp_txn.delete();
        exp_rsp.delete();
        no_resp = 0;
        cycle();
        rst = 1'b1;
        run_resps(1, 20);
        if (seen_own.size() > 0) chk("post_rst_owner", seen_own[seen_own.size() - 1], 1'b0);
        drain();

        chk("txn_left", exp_txn.size(), 0);
        chk("rsp_left", exp_rsp.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/cacheline_arbiter.md
# cacheline_arbiter

- Arbitrates between the I-cache and D-cache DFP ports and drives the single 256-bit cache-line DFP interface of the deserializer/bmem path.
- On grant, latches the winning request (address, write data, read/write) and holds it stable downstream until the line-level response returns.
- Routes the response back to the owning cache, then inserts one dead cycle before the next grant.

## Interface
Parameters:
- ADDR_W, 32, DFP address width
- LINE_W, 256, cache-line width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- i_dfp_addr  in  ADDR_W  I-cache line address
- i_dfp_read  in  1  I-cache line read request, held until i_dfp_resp
- i_dfp_rdata  out  LINE_W  line returned to I-cache
- i_dfp_resp  out  1  one-cycle completion pulse to I-cache
- d_dfp_addr  in  ADDR_W  D-cache line address
- d_dfp_read  in  1  D-cache line read request
- d_dfp_write  in  1  D-cache line writeback request
- d_dfp_wdata  in  LINE_W  writeback line
- d_dfp_rdata  out  LINE_W  line returned to D-cache
- d_dfp_resp  out  1  one-cycle completion pulse to D-cache
- dfp_addr  out  ADDR_W  latched address to deserializer
- dfp_read  out  1  latched read request
- dfp_write  out  1  latched write request
- dfp_wdata  out  LINE_W  latched writeback line
- dfp_rdata  in  LINE_W  line from deserializer
- dfp_resp  in  1  completion pulse from deserializer

## Operation
FSM states: IDLE, I_BUSY, D_BUSY, DONE.

- **IDLE**
  - No requester: stay in IDLE, all dfp_* outputs 0.
  - Single requester: grant it.
  - Both requesting: resolved per Configuration.
  - Grant I: latch i_dfp_addr, set read=1, write=0, go to I_BUSY.
  - Grant D: latch d_dfp_addr and d_dfp_wdata, go to D_BUSY.
  - d_dfp_read and d_dfp_write both high is illegal. Treat it as a write (write=1, read=0) and fire a simulation-only assertion.
- **I_BUSY / D_BUSY**
  - Latched outputs held constant. Upstream inputs are ignored.
  - When dfp_resp=1: pulse the owner's *_resp in the same cycle (combinational pass-through), clear dfp_read/dfp_write at that edge, go to DONE.
- **DONE**
  - Exactly one cycle. All requests ignored (the owner drops its request during this cycle). Go to IDLE.
- **Response routing**
  - i_dfp_rdata = dfp_rdata and i_dfp_resp = dfp_resp only while the state is I_BUSY; otherwise 0.
  - Same rule for the D-side with D_BUSY.
  - The non-owner never sees resp=1.
- **Spurious response:** dfp_resp in IDLE or DONE is dropped, and a simulation assertion fires.

## Timing
- **Reset values:** state=IDLE; dfp_addr=0, dfp_read=0, dfp_write=0, dfp_wdata=0; i_dfp_resp=0, d_dfp_resp=0; i_dfp_rdata=0, d_dfp_rdata=0; round-robin pointer = I-cache-next.
- **Grant latency:** request sampled in IDLE at edge N drives dfp_read/dfp_write high from cycle N+1 (registered outputs).
- **Response latency:** zero. dfp_resp in cycle M gives owner resp in cycle M.
- **Back-to-back:** after resp in cycle M, DONE occupies M+1 and IDLE occupies M+2. The next grant's outputs are visible at M+3.
- **Reset mid-transaction:** asynchronous reset aborts immediately and all outputs go to reset values. The deserializer shares the reset, so no partial line is forwarded.

## Configuration
- **ARB_ROUND_ROBIN_EN defined:** on simultaneous requests in IDLE, grant the side not granted last. The pointer updates on every grant, including uncontested grants.
- **ARB_ROUND_ROBIN_EN undefined:** fixed priority, D-cache always wins. There is no pointer register and the I-cache may starve under continuous D traffic.

## Structure
- Shared package `arb_pkg` contains:
  - `arb_state_t`, an enum of IDLE, I_BUSY, D_BUSY, DONE
  - `arb_owner_t`, an enum of OWN_I, OWN_D
  - constants ARB_ADDR_W and ARB_LINE_W
- Single flat module; no sub-module warranted. The request latch and FSM share one always_ff with asynchronous reset.

## Test plan
- **Lone I read:** i_dfp_read=1, addr 0x0000_1000 -> dfp_read=1 and dfp_addr=0x1000 next cycle. dfp_resp with rdata=0xA5…A5 -> i_dfp_resp=1 and i_dfp_rdata=0xA5…A5 same cycle; d_dfp_resp stays 0.
- **Lone D write:** d_dfp_write=1, addr 0x2000, wdata=0x1234…(256b) -> dfp_write=1 and dfp_wdata is held even if d_dfp_wdata changes mid-transaction. Resp -> d_dfp_resp pulse; DONE, then IDLE two cycles after resp.
- **Simultaneous requests, ARB_ROUND_ROBIN_EN defined:**
  - Both requesters held high -> grants alternate I, D, I, D across four transactions.
  - With the macro undefined -> D, D, D while D stays asserted.
- **Reset mid-operation:** rst low during D_BUSY -> all outputs 0 immediately. After release, a pending i_dfp_read is granted first.
- **Illegal/spurious inputs:**
  - d_dfp_read and d_dfp_write both high -> dfp_write=1, dfp_read=0, assertion fires.
  - dfp_resp in IDLE -> no *_resp pulse.
- **DONE dead cycle:** requester keeps its request high in the cycle after resp -> no re-grant in DONE; re-grant appears at M+3.
